// File: rtl/hilo_muldiv_if.sv
// Request/result bundle between the pipeline and the HI/LO multiply/divide sequencer.
interface hilo_muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cancel;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, cancel,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, a, b, cancel,
    output busy, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/hilo_muldiv_ctrl.sv
// Iterative shift-add multiply / restoring divide sequencer; sole owner of HI/LO.
//
// state | meaning
// IDLE  | waiting for start; mthi/mtlo are written here directly
// RUN   | one multiply/divide iteration per cycle, WIDTH cycles
// FIN   | sign correction and HI/LO write-back, pulse done
module hilo_muldiv_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  hilo_muldiv_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   opd_q;
  logic [WIDTH-1:0]   a_q;
  logic               is_div_q, dbz_q, qsign_q, rsign_q;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               done_q, dbz_pulse_q;

  logic               is_muldiv, is_signed, is_divop, b_zero;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum, rem_sh, diff;
  logic [2*WIDTH-1:0] mul_next, div_next, prod;
  logic [WIDTH-1:0]   quo, rem;

  assign is_muldiv = ~bus.op[2];
  assign is_signed = ~bus.op[0];
  assign is_divop  = bus.op[1];
  assign b_zero    = (bus.b == '0);
  assign a_mag     = (is_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign b_mag     = (is_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;

  // acc_q holds {hi, lo} partial product for multiply, {rem, quo} for divide
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opd_q};
  assign mul_next = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[2*WIDTH-1:1]};

  assign rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
  assign diff     = rem_sh - {1'b0, opd_q};
  assign div_next = diff[WIDTH] ? {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                : {diff[WIDTH-1:0],   acc_q[WIDTH-2:0], 1'b1};

  assign prod = qsign_q ? -acc_q : acc_q;
  assign quo  = qsign_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem  = rsign_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (bus.start && is_muldiv) state_d = (is_divop && b_zero) ? FIN : RUN;
      RUN: begin
        if (bus.cancel)         state_d = IDLE;
        else if (cnt_q == LAST) state_d = FIN;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      acc_q       <= '0;
      opd_q       <= '0;
      a_q         <= '0;
      is_div_q    <= 1'b0;
      dbz_q       <= 1'b0;
      qsign_q     <= 1'b0;
      rsign_q     <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
      done_q      <= 1'b0;
      dbz_pulse_q <= 1'b0;
    end else begin
      done_q      <= 1'b0;
      dbz_pulse_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            if (is_muldiv) begin
              acc_q    <= is_divop ? {{WIDTH{1'b0}}, a_mag} : {{WIDTH{1'b0}}, b_mag};
              opd_q    <= is_divop ? b_mag : a_mag;
              a_q      <= bus.a;
              is_div_q <= is_divop;
              dbz_q    <= is_divop & b_zero;
              qsign_q  <= is_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
              rsign_q  <= is_signed & bus.a[WIDTH-1];
              cnt_q    <= '0;
            end else if (bus.op == 3'b100) begin
              hi_q <= bus.a;
            end else if (bus.op == 3'b101) begin
              lo_q <= bus.a;
            end
          end
        end
        RUN: begin
          if (!bus.cancel) begin
            acc_q <= is_div_q ? div_next : mul_next;
            cnt_q <= cnt_q + 1'b1;
          end
        end
        FIN: begin
          if (!bus.cancel) begin
            done_q <= 1'b1;
            if (dbz_q) begin
              hi_q        <= a_q;
              lo_q        <= '1;
              dbz_pulse_q <= 1'b1;
            end else if (is_div_q) begin
              hi_q <= rem;
              lo_q <= quo;
            end else begin
              {hi_q, lo_q} <= prod;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy        = (state_q != IDLE);
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_pulse_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Randomized bench for hilo_muldiv_ctrl against an arithmetic model of HI/LO.
module tb_hilo_muldiv_ctrl;
  localparam int W = 32;

  logic        clk = 1'b0;
  logic        rst_n;
  int          total = 0;
  int          bad = 0;
  logic [31:0] m_hi, m_lo;

  hilo_muldiv_if #(.WIDTH(W)) bus ();
  hilo_muldiv_ctrl #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] eh, output logic [31:0] el, output logic ez);
    longint      sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    eh = m_hi; el = m_lo; ez = 1'b0;
    case (op)
      3'd0: begin p = sa * sb; {eh, el} = p; end
      3'd1: begin p = {32'd0, a} * {32'd0, b}; {eh, el} = p; end
      3'd2, 3'd3: begin
        if (b == 32'd0) begin
          eh = a; el = 32'hFFFF_FFFF; ez = 1'b1;
        end else if (op == 3'd2) begin
          q = sa / sb; r = sa % sb;
          el = q[31:0]; eh = r[31:0];
        end else begin
          el = a / b; eh = a % b;
        end
      end
      default: ;
    endcase
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int cancel_at, input int inj_at);
    logic [31:0] eh, el;
    logic        ez;
    int          cyc, nb;
    model(op, a, b, eh, el, ez);
    nb = (op[2] == 1'b0 && op[1] && b == 32'd0) ? 1 : W + 1;
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    @(negedge clk);
    bus.start = 1'b0; bus.op = 3'($urandom); bus.a = $urandom; bus.b = $urandom;
    if (op[2]) begin
      check("mv_busy", 64'(bus.busy), 64'd0);
      check("mv_done", 64'(bus.done), 64'd0);
      if (op == 3'b100) m_hi = a;
      else if (op == 3'b101) m_lo = a;
      check("mv_hi", 64'(bus.hi), 64'(m_hi));
      check("mv_lo", 64'(bus.lo), 64'(m_lo));
      return;
    end
    cyc = 0;
    while (bus.busy && cyc < 200) begin
      cyc++;
      if (cyc == cancel_at) bus.cancel = 1'b1;
      if (cyc == inj_at) begin bus.start = 1'b1; bus.op = 3'b100; end
      @(negedge clk);
      bus.cancel = 1'b0;
      bus.start  = 1'b0;
    end
    if (cancel_at >= 1 && cancel_at <= nb) begin
      check("cancel_cycles", 64'(cyc), 64'(cancel_at));
      check("cancel_done", 64'(bus.done), 64'd0);
      check("cancel_hi", 64'(bus.hi), 64'(m_hi));
      check("cancel_lo", 64'(bus.lo), 64'(m_lo));
      @(negedge clk);
      check("cancel_late_done", 64'(bus.done), 64'd0);
    end else begin
      m_hi = eh; m_lo = el;
      check("busy_cycles", 64'(cyc), 64'(nb));
      check("done", 64'(bus.done), 64'd1);
      check("dbz", 64'(bus.div_by_zero), 64'(ez));
      check("hi", 64'(bus.hi), 64'(m_hi));
      check("lo", 64'(bus.lo), 64'(m_lo));
      @(negedge clk);
      check("done_pulse", 64'(bus.done), 64'd0);
      check("dbz_pulse", 64'(bus.div_by_zero), 64'd0);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0; bus.op = 3'd0; bus.a = '0; bus.b = '0; bus.cancel = 1'b0;
    rst_n = 1'b0; m_hi = '0; m_lo = '0;
    #12;
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_dbz", 64'(bus.div_by_zero), 64'd0);
    check("rst_hi", 64'(bus.hi), 64'd0);
    check("rst_lo", 64'(bus.lo), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(3'd0, 32'hFFFF_FFFE, 32'h0000_0003, 0, 0);
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
    run_op(3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 0, 0);
    run_op(3'd3, 32'h0000_0007, 32'h0000_0002, 0, 0);
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    run_op(3'd3, 32'h0000_1234, 32'h0000_0000, 0, 0);

    // back-to-back moves on consecutive edges
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'b100; bus.a = 32'hCAFE_F00D;
    @(negedge clk);
    check("mthi_busy", 64'(bus.busy), 64'd0);
    check("mthi_hi", 64'(bus.hi), 64'h0000_0000_CAFE_F00D);
    bus.op = 3'b101; bus.a = 32'h1234_5678;
    @(negedge clk);
    bus.start = 1'b0;
    m_hi = 32'hCAFE_F00D; m_lo = 32'h1234_5678;
    check("mtlo_busy", 64'(bus.busy), 64'd0);
    check("mtlo_hi", 64'(bus.hi), 64'(m_hi));
    check("mtlo_lo", 64'(bus.lo), 64'(m_lo));

    run_op(3'd6, 32'hDEAD_BEEF, 32'd1, 0, 0);
    run_op(3'd1, 32'h0001_2345, 32'h0000_F00F, 0, 15);
    run_op(3'd0, 32'h7654_3210, 32'h8123_4567, 10, 0);
    run_op(3'd3, 32'h0000_9999, 32'h0000_0007, 33, 0);
    run_op(3'd2, 32'h0000_0005, 32'h0000_0000, 1, 0);

    // asynchronous reset mid-run
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'd0; bus.a = 32'h1111_1111; bus.b = 32'h2222_2222;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    m_hi = '0; m_lo = '0;
    check("arst_busy", 64'(bus.busy), 64'd0);
    check("arst_hi", 64'(bus.hi), 64'd0);
    check("arst_lo", 64'(bus.lo), 64'd0);
    check("arst_done", 64'(bus.done), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(3'd0, 32'hFFFF_FFF0, 32'h0000_0100, 0, 0);

    for (int i = 0; i < 40; i++) begin
      logic [2:0]  op;
      logic [31:0] a, b;
      int          nb, ca, ij;
      op = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = b >> $urandom_range(0, 31);
        2: a = 32'h8000_0000;
        default: ;
      endcase
      nb = (op[2] == 1'b0 && op[1] && b == 32'd0) ? 1 : W + 1;
      ca = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, nb)) : 0;
      ij = (nb > 1 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, nb - 1)) : 0;
      run_op(op, a, b, ca, ij);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/hilo_muldiv_ctrl.md
# hilo_muldiv_ctrl

Multi-cycle multiply/divide sequencer that owns the architectural HI/LO registers for the MIPS datapath. It runs iterative radix-2 shift-add multiplication and restoring division beside the single-cycle ALU. It raises Busy so hazard logic can stall HI/LO consumers (mfhi/mflo, a new mult/div) until the result is written. MTHI/MTLO writes go through the same block, which keeps HI/LO single-owner.

## Interface
- WIDTH, 32, operand width; HI/LO each WIDTH bits; iteration count = WIDTH
- Clk  in  1  system clock, rising edge
- Reset_n  in  1  one clock; reset is asynchronous and active-low
- Start  in  1  request valid; sampled only in IDLE
- Op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x reserved (no effect)
- A  in  WIDTH  rs operand (dividend / multiplicand / move source)
- B  in  WIDTH  rt operand (divisor / multiplier)
- Cancel  in  1  pipeline flush; aborts an in-flight operation
- Busy  out  1  high whenever state != IDLE
- Done  out  1  one-cycle pulse when HI/LO are updated by mul/div
- DivByZero  out  1  one-cycle pulse coincident with Done for DIV/DIVU with B == 0
- Hi  out  WIDTH  architectural HI register
- Lo  out  WIDTH  architectural LO register

## Operation
- States: IDLE, RUN, FIN. Counter is log2(WIDTH)+1 bits.
- On reset, all outputs are 0: Hi, Lo, Busy, Done, DivByZero. State = IDLE, counter = 0.
- IDLE with Start and a mul/div Op:
  - Latch the operand magnitudes. Signed ops use two's-complement absolute values, treated as unsigned WIDTH bits. Unsigned ops use raw operands.
  - Latch the sign flags: product/quotient sign = A[msb]^B[msb]; remainder sign = A[msb]. Both are 0 for unsigned ops.
  - Clear the counter and go to RUN.
- DIV/DIVU with B == 0: go straight to FIN with a div-by-zero flag set.
- IDLE with Start and MTHI/MTLO: Hi (or Lo) <= A at that edge. Busy stays 0, no Done, the other register is unchanged.
- IDLE with Start and reserved Op: no state change.
- RUN, one iteration per cycle, WIDTH cycles:
  - Multiply: 2*WIDTH-bit accumulator. Add the multiplicand when the current multiplier LSB is 1, then shift right.
  - Divide: restoring. Shift {rem, quo} left by 1, trial-subtract the divisor, keep the result if non-negative, set quo LSB.
  - Counter == WIDTH-1 goes to FIN.
- FIN, one cycle, then IDLE:
  - Apply sign correction: negate the 2*WIDTH product if its sign flag is set. Negate the quotient and remainder independently by their flags.
  - Write HI/LO: mul gives Hi = product[2W-1:W], Lo = product[W-1:0]; div gives Lo = quotient, Hi = remainder.
  - Pulse Done.
  - Div-by-zero result: Hi = A, Lo = all ones, DivByZero = 1.
- Signed overflow 0x80000000 / 0xFFFFFFFF gives Lo = 0x80000000, Hi = 0. This is a natural consequence of the magnitude path.
- Cancel in RUN or FIN: go to IDLE next edge. HI/LO are not written, no Done. Cancel takes priority over FIN completion.
- Cancel in IDLE: ignored. Start and Cancel in the same IDLE cycle: Start wins.
- Start while Busy: ignored, with no queueing. The hazard unit is responsible for holding the instruction.
- Reset_n low at any time: immediate return to reset values, with no partial HI/LO update.

## Timing
- Edge E0: Start sampled in IDLE. Busy = 1 from after E0.
- E1..E32: RUN iterations (WIDTH = 32).
- E33: FIN writes HI/LO, state -> IDLE. Busy = 0 and Done = 1 during the cycle after E33.
- Latency is WIDTH+1 edges from Start to HI/LO valid. A new Start is accepted at E34 or later.
- Div-by-zero: E0 goes to FIN, E1 writes. Busy is high for one cycle.
- Done and DivByZero are registered and high exactly one cycle.
- Busy is derived only from the state register, with no combinational path from Start.
- MTHI/MTLO take effect at the sampling edge. The new value is visible the next cycle.

## Test plan
- MULT A=0xFFFFFFFE (-2), B=0x00000003 -> after 33 Busy cycles Hi=0xFFFFFFFF, Lo=0xFFFFFFFA, Done pulse 1 cycle.
- MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> Hi=0xFFFFFFFE, Lo=0x00000001.
- DIV A=-7 (0xFFFFFFF9), B=2 -> Lo=0xFFFFFFFD (-3), Hi=0xFFFFFFFF (-1). DIVU A=7, B=2 -> Lo=3, Hi=1. DIV 0x80000000/0xFFFFFFFF -> Lo=0x80000000, Hi=0.
- DIVU A=0x1234, B=0 -> Busy for 1 cycle, Hi=0x1234, Lo=0xFFFFFFFF, Done and DivByZero pulse together.
- MTHI A=0xCAFEF00D then MTLO A=0x12345678 on consecutive cycles -> Hi and Lo updated, Busy never high. Start during RUN -> ignored, result unaffected.
- Assert Cancel at RUN iteration 10 -> IDLE next cycle, Hi/Lo unchanged, no Done. Drop Reset_n mid-RUN -> all outputs 0 asynchronously, and a new MULT after release completes correctly.
